// File: rtl/cp0_pkg.sv
// Shared encodings for the coprocessor-0 interrupt/exception unit:
// register selects, ExcCode values and Status nibble geometry.
package cp0_pkg;

  typedef enum logic [1:0] {
    SEL_STATUS = 2'd0,
    SEL_CAUSE  = 2'd1,
    SEL_EPC    = 2'd2,
    SEL_MASK   = 2'd3
  } c0_sel_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int unsigned NIB_W = 4;

  // Bits of Status that hold live levels; anything shifted above is discarded.
  function automatic logic [31:0] status_keep_mask(input int unsigned levels);
    if (levels >= 32 / NIB_W) return '1;
    return (32'd1 << (levels * NIB_W)) - 32'd1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module irq_prio_enc #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] id_o
);

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o = 1'b1;
        id_o    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt/exception unit: Status/Cause/EPC/Mask, irq latching,
// exception vs. interrupt arbitration and next-PC redirection with nesting.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [15:0] EDGE_MASK  = 16'h00FF,
  parameter logic [31:0] EXC_BASE   = 32'h0000_0040,
  parameter bit          VECTORED   = 1'b1,
  parameter logic [31:0] VEC_STRIDE = 32'h20,
  parameter int unsigned NEST_MAX   = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ov,
  input  logic               sys,
  input  logic               eret,
  input  logic               c0_we,
  input  logic [1:0]         c0_sel,
  input  logic [31:0]        c0_wdata,
  output logic [31:0]        c0_rdata,
  input  logic [31:0]        cur_pc,
  input  logic [31:0]        seq_pc,
  output logic [31:0]        next_pc,
  output logic               inta,
  output logic [3:0]         int_id,
  output logic               nest_ovf
);

  localparam logic [NUM_IRQ-1:0] EDGE      = EDGE_MASK[NUM_IRQ-1:0];
  localparam logic [31:0]        ST_KEEP   = status_keep_mask(NEST_MAX + 1);
  localparam logic [2:0]         DEPTH_MAX = 3'(NEST_MAX);

  logic [31:0]        status_q, status_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        mask_q, mask_d;
  logic [4:0]         exc_q, exc_d;
  logic [2:0]         depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] elig, ack_mask;
  logic [31:0]        cause_w;
  logic               enc_valid;
  logic [3:0]         enc_id;
  logic               sync_exc, csr_defer, take_irq, do_eret;

  assign elig = pend_q & mask_q[NUM_IRQ-1:0];

  irq_prio_enc #(.N(NUM_IRQ), .IW(4)) u_prio (
    .req_i   (elig),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  always_comb begin
    cause_w                = '0;
    cause_w[8 +: NUM_IRQ]  = pend_q;
    cause_w[6:2]           = exc_q;
  end

  assign sync_exc  = (ov | sys) & ~Rst;
  assign csr_defer = c0_we & ((c0_sel == SEL_STATUS) | (c0_sel == SEL_MASK));
  assign take_irq  = enc_valid & status_q[0] & (depth_q < DEPTH_MAX)
                   & ~ov & ~sys & ~eret & ~csr_defer & ~Rst;
  assign do_eret   = eret & ~sync_exc & ~Rst;

  always_comb begin
    if (sync_exc)      next_pc = EXC_BASE;
    else if (take_irq) next_pc = VECTORED ? EXC_BASE + (32'(enc_id) + 32'd1) * VEC_STRIDE
                                          : EXC_BASE;
    else if (do_eret)  next_pc = epc_q;
    else               next_pc = seq_pc;
  end

  assign inta     = take_irq;
  assign int_id   = take_irq ? enc_id : '0;
  assign nest_ovf = ovf_q;

  always_comb begin
    case (c0_sel)
      SEL_STATUS: c0_rdata = status_q;
      SEL_CAUSE:  c0_rdata = cause_w;
      SEL_EPC:    c0_rdata = epc_q;
      default:    c0_rdata = mask_q;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      ack_mask[i] = take_irq && (enc_id == 4'(i));
    end
    pend_d = (EDGE & ((pend_q & ~ack_mask) | (irq & ~irq_q))) | (~EDGE & irq);
  end

  // A taken interrupt owns EPC/Cause that cycle, and eret owns Status, so
  // those take precedence over a coincident mtc0; other mtc0 targets still land.
  always_comb begin
    status_d = status_q;
    epc_d    = epc_q;
    mask_d   = mask_q;
    exc_d    = exc_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    if (sync_exc) begin
      status_d = (status_q << NIB_W) & ST_KEEP;
      epc_d    = cur_pc;
      exc_d    = ov ? EXC_OV : EXC_SYS;
      if (depth_q == DEPTH_MAX) ovf_d   = 1'b1;
      else                      depth_d = depth_q + 3'd1;
    end else begin
      if (c0_we) begin
        case (c0_sel)
          SEL_STATUS: status_d = c0_wdata & ST_KEEP;
          SEL_CAUSE:  exc_d    = c0_wdata[6:2];
          SEL_EPC:    epc_d    = c0_wdata;
          default:    mask_d   = c0_wdata;
        endcase
      end
      if (take_irq) begin
        status_d = (status_q << NIB_W) & ST_KEEP;
        epc_d    = seq_pc;
        exc_d    = EXC_INT;
        depth_d  = depth_q + 3'd1;
      end else if (do_eret) begin
        status_d = status_q >> NIB_W;
        if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      status_q <= '0;
      epc_q    <= '0;
      mask_q   <= '1;
      exc_q    <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= '0;
      pend_q   <= '0;
    end else begin
      status_q <= status_d;
      epc_q    <= epc_d;
      mask_q   <= mask_d;
      exc_q    <= exc_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Table-driven bench for cp0_intc: a default-parameter instance and a
// non-vectored NEST_MAX=1 instance with line 5 level-sensitive.
module tb_cp0_intc;

  localparam logic [1:0] S = 2'd0, C = 2'd1, E = 2'd2, M = 2'd3;

  logic        Clk = 1'b0;
  logic        Rst, ov, sys, eret, c0_we;
  logic [7:0]  irq;
  logic [1:0]  c0_sel;
  logic [31:0] c0_wdata, cur_pc, seq_pc;

  logic [31:0] rd1, npc1, rd2, npc2;
  logic        inta1, ovf1, inta2, ovf2;
  logic [3:0]  id1, id2;

  always #5 Clk = ~Clk;

  cp0_intc u_dut1 (
    .Clk(Clk), .Rst(Rst), .irq(irq), .ov(ov), .sys(sys), .eret(eret),
    .c0_we(c0_we), .c0_sel(c0_sel), .c0_wdata(c0_wdata), .c0_rdata(rd1),
    .cur_pc(cur_pc), .seq_pc(seq_pc), .next_pc(npc1), .inta(inta1),
    .int_id(id1), .nest_ovf(ovf1)
  );

  cp0_intc #(.NEST_MAX(1), .VECTORED(1'b0), .EDGE_MASK(16'h00DF)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .irq(irq), .ov(ov), .sys(sys), .eret(eret),
    .c0_we(c0_we), .c0_sel(c0_sel), .c0_wdata(c0_wdata), .c0_rdata(rd2),
    .cur_pc(cur_pc), .seq_pc(seq_pc), .next_pc(npc2), .inta(inta2),
    .int_id(id2), .nest_ovf(ovf2)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        ov, sys, eret, we;
    logic [1:0]  sel;
    logic [31:0] wdata, pc;
    logic [31:0] npc;
    logic        inta;
    logic [3:0]  id;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ovf;
    int unsigned dut;
  } vec_t;

  typedef struct {
    logic [31:0] npc;
    logic        inta;
    logic [3:0]  id;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ovf;
    int unsigned dut;
    int unsigned row;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int unsigned n_pass = 0, n_total = 0;

  function automatic vec_t mk(input logic rst, input logic [7:0] irq_v, input logic ov_v,
                              input logic sys_v, input logic eret_v, input logic we_v,
                              input logic [1:0] sel_v, input logic [31:0] wd, input logic [31:0] pc,
                              input logic [31:0] npc, input logic ia, input logic [3:0] id,
                              input logic chk, input logic [31:0] rd, input logic ovf,
                              input int unsigned dut);
    vec_t v;
    v.rst = rst; v.irq = irq_v; v.ov = ov_v; v.sys = sys_v; v.eret = eret_v; v.we = we_v;
    v.sel = sel_v; v.wdata = wd; v.pc = pc; v.npc = npc; v.inta = ia; v.id = id;
    v.chk_rd = chk; v.rd = rd; v.ovf = ovf; v.dut = dut;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  initial begin
    exp_t e;
    Rst = 1'b1; irq = '0; ov = 0; sys = 0; eret = 0; c0_we = 0; c0_sel = M;
    c0_wdata = '0; cur_pc = 32'h1000; seq_pc = 32'h1004;

    // Hand-written reset check: redirect idle, Mask reads all ones.
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_npc1", 0, npc1, 32'h1004);
    chk("rst_npc2", 0, npc2, 32'h1004);
    chk("rst_inta1", 0, {31'd0, inta1}, 32'd0);
    chk("rst_inta2", 0, {31'd0, inta2}, 32'd0);
    chk("rst_ovf1", 0, {31'd0, ovf1}, 32'd0);
    chk("rst_mask1", 0, rd1, 32'hFFFF_FFFF);
    chk("rst_mask2", 0, rd2, 32'hFFFF_FFFF);

    // Instance 1: edge irq[3], ov vs pending irq[0], nesting, eret+mtc0, Mask, Rst mid-handler.
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h100, 'h104,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,M,0,'h104, 'h108,0,0,1,'hFFFF_FFFF,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,C,0,'h108, 'h10C,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,E,0,'h10C, 'h110,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,1,S,1,'h110, 'h114,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h08,0,0,0,0,S,0,'h114, 'h118,0,0,1,'h1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,C,0,'h200, 'hC0,1,3,1,'h800,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h300, 'h304,0,0,1,'h10,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,E,0,'h304, 'h308,0,0,1,'h204,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,C,0,'h308, 'h30C,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,1,0,E,0,'h30C, 'h204,0,0,1,'h204,0,0));
    tbl.push_back(mk(0,8'h01,0,0,0,0,S,0,'h204, 'h208,0,0,1,'h1,0,0));
    tbl.push_back(mk(0,8'h00,1,0,0,0,C,0,'h400, 'h40,0,0,1,'h100,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,C,0,'h40,  'h44,0,0,1,'h130,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,E,0,'h44,  'h48,0,0,1,'h400,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,1,S,'h11,'h48,'h4C,0,0,1,'h10,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h500, 'h60,1,0,1,'h11,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h60,  'h64,0,0,1,'h110,0,0));
    tbl.push_back(mk(0,8'h00,0,0,1,0,E,0,'h64,  'h504,0,0,1,'h504,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,1,E,'h404,'h504,'h508,0,0,1,'h504,0,0));
    tbl.push_back(mk(0,8'h00,0,0,1,0,S,0,'h508, 'h404,0,0,1,'h11,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h404, 'h408,0,0,1,'h1,0,0));
    tbl.push_back(mk(0,8'h00,0,0,1,1,E,'h777,'h408,'h404,0,0,1,'h404,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,E,0,'h404, 'h408,0,0,1,'h777,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h408, 'h40C,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,1,S,1,'h40C, 'h410,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h10,0,0,0,1,M,0,'h410, 'h414,0,0,1,'hFFFF_FFFF,0,0));
    tbl.push_back(mk(0,8'h10,0,0,0,0,C,0,'h414, 'h418,0,0,1,'h1000,0,0));
    tbl.push_back(mk(0,8'h10,0,0,0,1,M,'hFF,'h418,'h41C,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h10,0,0,0,1,S,1,'h41C, 'h420,0,0,1,'h1,0,0));
    tbl.push_back(mk(0,8'h10,0,0,0,0,C,0,'h600, 'hE0,1,4,1,'h1000,0,0));
    tbl.push_back(mk(1,8'h04,0,0,0,0,S,0,'hE0,  'hE4,0,0,0,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h100, 'h104,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,C,0,'h104, 'h108,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,E,0,'h108, 'h10C,0,0,1,'h0,0,0));
    tbl.push_back(mk(0,8'h00,0,0,0,0,M,0,'h10C, 'h110,0,0,1,'hFFFF_FFFF,0,0));

    // Instance 2: level irq[5], NEST_MAX=1 blocking, sys at max depth, re-ack after eret.
    tbl.push_back(mk(1,8'h00,0,0,0,0,S,0,'h100, 'h104,0,0,0,'h0,0,1));
    tbl.push_back(mk(0,8'h00,0,0,0,1,S,1,'h104, 'h108,0,0,1,'h0,0,1));
    tbl.push_back(mk(0,8'h20,0,0,0,0,S,0,'h108, 'h10C,0,0,1,'h1,0,1));
    tbl.push_back(mk(0,8'h20,0,0,0,0,S,0,'h600, 'h40,1,5,1,'h1,0,1));
    tbl.push_back(mk(0,8'h20,0,0,0,0,S,0,'h40,  'h44,0,0,1,'h10,0,1));
    tbl.push_back(mk(0,8'h24,0,0,0,0,C,0,'h44,  'h48,0,0,1,'h2000,0,1));
    tbl.push_back(mk(0,8'h24,0,0,0,1,S,'h11,'h48,'h4C,0,0,1,'h10,0,1));
    tbl.push_back(mk(0,8'h24,0,0,0,0,C,0,'h4C,  'h50,0,0,1,'h2400,0,1));
    tbl.push_back(mk(0,8'h24,0,1,0,0,S,0,'h700, 'h40,0,0,1,'h11,0,1));
    tbl.push_back(mk(0,8'h24,0,0,0,0,C,0,'h40,  'h44,0,0,1,'h2420,1,1));
    tbl.push_back(mk(0,8'h24,0,0,0,0,S,0,'h44,  'h48,0,0,1,'h10,1,1));
    tbl.push_back(mk(0,8'h24,0,0,1,0,E,0,'h48,  'h700,0,0,1,'h700,1,1));
    tbl.push_back(mk(0,8'h24,0,0,0,0,S,0,'h800, 'h40,1,2,1,'h1,1,1));
    tbl.push_back(mk(0,8'h24,0,0,1,0,S,0,'h40,  'h804,0,0,1,'h10,1,1));
    tbl.push_back(mk(0,8'h20,0,0,0,0,S,0,'h900, 'h40,1,5,1,'h1,1,1));
    tbl.push_back(mk(0,8'h00,0,0,0,0,S,0,'h40,  'h44,0,0,1,'h10,1,1));

    for (int unsigned k = 0; k < tbl.size(); k++) begin
      @(posedge Clk);
      #1;
      Rst = tbl[k].rst; irq = tbl[k].irq; ov = tbl[k].ov; sys = tbl[k].sys;
      eret = tbl[k].eret; c0_we = tbl[k].we; c0_sel = tbl[k].sel;
      c0_wdata = tbl[k].wdata; cur_pc = tbl[k].pc; seq_pc = tbl[k].pc + 32'd4;
      e.npc = tbl[k].npc; e.inta = tbl[k].inta; e.id = tbl[k].id; e.chk_rd = tbl[k].chk_rd;
      e.rd = tbl[k].rd; e.ovf = tbl[k].ovf; e.dut = tbl[k].dut; e.row = k;
      sb.push_back(e);
      #5;
      e = sb.pop_front();
      if (e.dut == 0) begin
        chk("next_pc", e.row, npc1, e.npc);
        chk("inta", e.row, {31'd0, inta1}, {31'd0, e.inta});
        chk("int_id", e.row, {28'd0, id1}, {28'd0, e.id});
        chk("nest_ovf", e.row, {31'd0, ovf1}, {31'd0, e.ovf});
        if (e.chk_rd) chk("c0_rdata", e.row, rd1, e.rd);
      end else begin
        chk("next_pc", e.row, npc2, e.npc);
        chk("inta", e.row, {31'd0, inta2}, {31'd0, e.inta});
        chk("int_id", e.row, {28'd0, id2}, {28'd0, e.id});
        chk("nest_ovf", e.row, {31'd0, ovf2}, {31'd0, e.ovf});
        if (e.chk_rd) chk("c0_rdata", e.row, rd2, e.rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
